// File: rtl/color_mem_writer.sv
// Packs a valid/ready stream of 4-bit nibbles into 12-bit RGB words and stores them
// sequentially in a palette memory with a registered read port for the pixel path.
module color_mem_writer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iClear,
    input  logic [3:0]    iNibble,
    input  logic          iValid,
    output logic          oReady,
    input  logic [AW-1:0] iRdAddr,
    output logic [11:0]   oColor,
    output logic [AW:0]   oCount,
    output logic          oFull
);

    localparam int unsigned NW = 4;
    localparam int unsigned CW = 12;

    typedef enum logic [1:0] {
        N0   = 2'd0,
        N1   = 2'd1,
        N2   = 2'd2,
        FULL = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [NW-1:0]  hold0_q, hold0_d;
    logic [NW-1:0]  hold1_q, hold1_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW:0]    count_q, count_d;
    logic [CW-1:0]  color_q;
    logic [CW-1:0]  mem_q [DEPTH];

    logic           accept_c;
    logic           we_c;
    logic [CW-1:0]  wdata_c;

    assign oReady   = (state_q != FULL);
    assign accept_c = iValid && oReady;
    assign oColor   = color_q;
    assign oCount   = count_q;
    assign oFull    = (count_q == (AW+1)'(DEPTH));

    // Next-state, nibble holding and write-side bookkeeping
    always_comb begin
        state_d = state_q;
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        we_c    = 1'b0;
        wdata_c = {iNibble, hold1_q, hold0_q};

        if (iClear) begin
            // Clear wins over a simultaneous handshake; that nibble is dropped
            state_d = N0;
            wptr_d  = '0;
            count_d = '0;
        end else if (accept_c) begin
            unique case (state_q)
                N0: begin
                    hold0_d = iNibble;
                    state_d = N1;
                end
                N1: begin
                    hold1_d = iNibble;
                    state_d = N2;
                end
                N2: begin
                    we_c    = 1'b1;
                    wptr_d  = wptr_q + AW'(1);
                    count_d = count_q + (AW+1)'(1);
                    state_d = (wptr_q == AW'(DEPTH - 1)) ? FULL : N0;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= N0;
            hold0_q <= '0;
            hold1_q <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Palette storage is never cleared; stale entries stay readable
    always_ff @(posedge iClk) begin
        if (we_c && !iRst) begin
            mem_q[wptr_q] <= wdata_c;
        end
    end

    // Read-before-write: a same-address write shows up on the following read
    always_ff @(posedge iClk) begin
        if (iRst) begin
            color_q <= '0;
        end else begin
            color_q <= mem_q[iRdAddr];
        end
    end

endmodule

// File: tb/tb_color_mem_writer.sv
// Directed bench for color_mem_writer: a queue-based palette model checked every cycle,
// plus hand-computed expectations at key points.
module tb_color_mem_writer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic [3:0]    nib = 4'h0;
    logic          valid = 1'b0;
    logic          ready;
    logic [AW-1:0] rdaddr = '0;
    logic [11:0]   color;
    logic [AW:0]   count;
    logic          full;

    int vectors = 0;
    int miscompares = 0;

    color_mem_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .iClk(clk), .iRst(rst), .iClear(clear), .iNibble(nib), .iValid(valid),
        .oReady(ready), .iRdAddr(rdaddr), .oColor(color), .oCount(count), .oFull(full)
    );

    always #5 clk = ~clk;

    // Model: pending nibbles in a queue, palette as a plain array, count doubles as write index
    logic [3:0]  pend[$];
    logic [11:0] mmem [DEPTH];
    bit          mknown [DEPTH];
    int          mcnt = 0;
    logic [11:0] exp_color = '0;
    bit          color_known = 1'b0;
    bit          chk_en = 1'b0;

    initial for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            mcnt = 0;
            exp_color = 12'h000;
            color_known = 1'b1;
            chk_en = 1'b1;
        end else begin
            exp_color = mmem[rdaddr];
            color_known = mknown[rdaddr];
            if (clear) begin
                pend.delete();
                mcnt = 0;
            end else if (valid && mcnt < DEPTH) begin
                pend.push_back(nib);
                if (pend.size() == 3) begin
                    mmem[mcnt] = {pend[2], pend[1], pend[0]};
                    mknown[mcnt] = 1'b1;
                    mcnt++;
                    pend.delete();
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", int'(ready), (mcnt < DEPTH) ? 1 : 0);
            check("count", int'(count), mcnt);
            check("full", int'(full), (mcnt == DEPTH) ? 1 : 0);
            if (color_known) check("color", int'(color), int'(exp_color));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] n);
        valid = 1'b1;
        nib = n;
        tick();
        valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [11:0] exp, input string name);
        rdaddr = a;
        tick();
        check(name, int'(color), int'(exp));
    endtask

    logic [3:0] gap_nibs [12];

    initial begin
        // Reset held two cycles with a valid nibble on the bus
        rst = 1'b1; valid = 1'b1; nib = 4'hF;
        tick(); tick();
        rst = 1'b0; valid = 1'b0;
        check("rst_ready", int'(ready), 1);
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        check("rst_color", int'(color), 12'h000);

        // Single word A,B,C
        send(4'hA); send(4'hB); send(4'hC);
        check("single_count", int'(count), 1);
        rd(4'd0, 12'hCBA, "single_word");

        // Fill to DEPTH: word i carries nibbles i, i+1, i+2
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            for (int k = 0; k < 3; k++) send(4'(i + k));
        check("fill_full", int'(full), 1);
        check("fill_ready", int'(ready), 0);
        for (int i = 0; i < 5; i++) send(4'(9 + i));
        check("fill_count_hold", int'(count), 16);
        rd(4'd15, 12'h10F, "fill_entry15");
        rd(4'd3, 12'h543, "fill_entry3");

        // Clear mid-word drops the nibble presented with it
        send(4'h9); send(4'h9);
        clear = 1'b1; valid = 1'b1; nib = 4'h7;
        tick();
        clear = 1'b0; valid = 1'b0;
        check("clear_count", int'(count), 0);
        check("clear_ready", int'(ready), 1);
        send(4'h1); send(4'h2); send(4'h3);
        rd(4'd0, 12'h321, "clear_entry0");

        // Read-during-write on entry 0: old 5A5, new 123
        do_clear();
        send(4'h5); send(4'hA); send(4'h5);
        do_clear();
        send(4'h3); send(4'h2);
        rdaddr = 4'd0;
        send(4'h1);
        check("rdw_old", int'(color), 12'h5A5);
        tick();
        check("rdw_new", int'(color), 12'h123);

        // Gapped valid with junk on the bus while idle
        do_clear();
        for (int k = 0; k < 12; k++) gap_nibs[k] = 4'(k * 5 + 1);
        for (int k = 0; k < 12; k++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                nib = 4'($urandom_range(0, 15));
                tick();
            end
            send(gap_nibs[k]);
        end
        check("gap_count", int'(count), 4);
        rd(4'd0, 12'hB61, "gap_w0");
        rd(4'd1, 12'hA50, "gap_w1");
        rd(4'd2, 12'h94F, "gap_w2");
        rd(4'd3, 12'h83E, "gap_w3");

        // Reset mid-word; memory survives, next nibble restarts the word
        send(4'h4); send(4'h4);
        rst = 1'b1; tick(); rst = 1'b0;
        send(4'hC); send(4'hD); send(4'hE);
        rd(4'd0, 12'hEDC, "rst_midword");
        rd(4'd1, 12'hA50, "stale_entry1");
        check("rst_midword_count", int'(count), 1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/color_mem_writer.md
# color_mem_writer

Write-side counterpart of the 4-bit-per-channel color ROM. Accepts a stream of 4-bit nibbles over a valid/ready handshake, packs each group of three into a 12-bit RGB color word, and stores the words sequentially in an internal palette memory of DEPTH entries. A registered read port supplies the stored colors to the VGA pixel path in the same 12-bit format the ROM produces.

## Interface
Parameters:
- DEPTH, 16: number of 12-bit color entries; power of two, ≥2
- AW, 4: address width; log2(DEPTH)

Ports:
- iClk  in  1  system clock; all logic on rising edge
- iRst  in  1  synchronous, active-high reset
- iClear  in  1  one-cycle pulse; restart loading at entry 0, discard partial word
- iNibble  in  4  nibble data
- iValid  in  1  iNibble valid
- oReady  out  1  block can accept a nibble this cycle
- iRdAddr  in  AW  read address
- oColor  out  12  registered read data, mem[iRdAddr] one cycle later
- oCount  out  AW+1  number of complete words written since reset/clear
- oFull  out  1  high when oCount == DEPTH

## Operation
- Nibble accepted on a cycle with iValid && oReady.
- Packing order: 1st accepted nibble -> word[3:0], 2nd -> word[7:4], 3rd -> word[11:8].
- FSM states: N0 (awaiting nibble 1), N1 (awaiting 2), N2 (awaiting 3), FULL.
  - N0 -accept-> N1; N1 -accept-> N2.
  - N2 -accept-> write {nib3, hold1, hold0} to mem[wptr], wptr+1, oCount+1; next state N0, or FULL if this was entry DEPTH-1.
  - FULL: oReady=0, no transitions except iClear/iRst.
  - No accept: hold state.
- oReady = (state != FULL). Combinational from state only, never from iValid.
- iClear: next state N0, wptr=0, oCount=0, holding registers ignored. iClear takes priority over a simultaneous accept; that nibble is dropped (it was handshaken but is not stored).
- Memory contents are not cleared by iRst or iClear; stale entries stay readable until overwritten.
- Read port: oColor <= mem[iRdAddr] every cycle, independent of FSM state.
- Same-cycle write and read of the same address: oColor returns the old contents (read-before-write); new data visible on the next read.
- wptr width AW wraps naturally; wrapping is unreachable because FULL blocks further writes.

## Timing
- Reset values (cycle after iRst sampled high): state N0, oReady=1, oCount=0, oFull=0, oColor=12'h000, holding registers 0.
- iRst has priority over iClear and over any handshake.
- Write latency: mem entry updated on the same edge that accepts the 3rd nibble; oCount/oFull update on that edge.
- Read latency: 1 cycle from iRdAddr to oColor.
- Throughput: one nibble per cycle; one word per 3 cycles sustained.
- oFull rises on the edge that writes entry DEPTH-1; oReady falls on that edge.
- Reset mid-word: partial nibbles discarded, next accepted nibble is nibble 1.

## Test plan
- Reset: hold iRst 2 cycles with iValid=1 -> oReady=1, oCount=0, oFull=0, oColor=000, no write occurs.
- Single word: nibbles A,B,C back-to-back from reset; read addr 0 -> oColor=12'hCBA one cycle after address presented; oCount=1.
- Fill + backpressure: DEPTH=16, stream 48 nibbles -> oFull=1 and oReady=0 after 48th; further nibbles with iValid=1 leave oCount=16 and memory unchanged; entry 15 reads the last packed word.
- iClear mid-word: send 2 nibbles, pulse iClear with iValid=1 and nibble 7 -> nibble 7 dropped, oCount=0; next 3 nibbles 1,2,3 land at entry 0 as 12'h321.
- Read-during-write: iRdAddr=0 on the cycle entry 0 is written (old 0x5A5, new 0x123) -> oColor=0x5A5 next cycle, 0x123 the cycle after.
- Gapped valid: random iValid gaps between nibbles -> packed words identical to the back-to-back case.
